// File: rtl/sdram_read_arbiter.sv
// Arbitrates the single SDRAM read port between the video fetch path and the ROM/asset path.
// Video has priority, bounded by a streak limit; a watchdog aborts bursts whose beats stop arriving.
module sdram_read_arbiter #(
  parameter int VIDEO_BURST_LEN  = 8,
  parameter int ROM_BURST_LEN    = 1,
  parameter int MAX_VIDEO_STREAK = 4,
  parameter int TIMEOUT_CYCLES   = 1023
) (
  input  logic        clk_sys_99_287,
  input  logic        reset_n,

  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_valid,
  output logic [15:0] vid_data,
  output logic        vid_done,

  input  logic        rom_req,
  input  logic [24:0] rom_addr,
  output logic        rom_ack,
  output logic        rom_valid,
  output logic [15:0] rom_data,
  output logic        rom_done,

  output logic        sd_rd,
  output logic [24:0] sd_rd_addr,
  input  logic        sd_data_available,
  input  logic [15:0] sd_out,
  output logic        sd_end_burst,
  output logic        timeout_err
);

  localparam int MAX_LEN = (VIDEO_BURST_LEN > ROM_BURST_LEN) ? VIDEO_BURST_LEN : ROM_BURST_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] VID_LEN      = CNT_W'(VIDEO_BURST_LEN);
  localparam logic [CNT_W-1:0] ROM_LEN      = CNT_W'(ROM_BURST_LEN);
  localparam logic [WD_W-1:0]  WD_LIMIT     = WD_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       STREAK_LIMIT = 4'(MAX_VIDEO_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_owner_rom;
  logic [3:0]       r_streak;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [WD_W-1:0]  r_wd_cnt;

  logic             r_sd_rd;
  logic [24:0]      r_sd_rd_addr;
  logic             r_sd_end_burst;
  logic             r_timeout_err;
  logic             r_vid_ack;
  logic             r_vid_valid;
  logic [15:0]      r_vid_data;
  logic             r_vid_done;
  logic             r_rom_ack;
  logic             r_rom_valid;
  logic [15:0]      r_rom_data;
  logic             r_rom_done;

  logic             w_any_req;
  logic             w_grant_rom;
  logic [CNT_W-1:0] w_burst_len;
  logic [CNT_W-1:0] w_beat_inc;
  logic [WD_W-1:0]  w_wd_inc;

  function automatic logic [3:0] streak_sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  // ROM only wins over a pending video request once video has used up its streak allowance.
  assign w_any_req   = vid_req | rom_req;
  assign w_grant_rom = rom_req & (~vid_req | (r_streak == STREAK_LIMIT));
  assign w_burst_len = r_owner_rom ? ROM_LEN : VID_LEN;
  assign w_beat_inc  = r_beat_cnt + CNT_W'(1);
  assign w_wd_inc    = r_wd_cnt + WD_W'(1);

  always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_owner_rom    <= 1'b0;
      r_streak       <= 4'd0;
      r_beat_cnt     <= '0;
      r_wd_cnt       <= '0;
      r_sd_rd        <= 1'b0;
      r_sd_rd_addr   <= 25'd0;
      r_sd_end_burst <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_vid_ack      <= 1'b0;
      r_vid_valid    <= 1'b0;
      r_vid_data     <= 16'd0;
      r_vid_done     <= 1'b0;
      r_rom_ack      <= 1'b0;
      r_rom_valid    <= 1'b0;
      r_rom_data     <= 16'd0;
      r_rom_done     <= 1'b0;
    end else begin
      r_sd_rd        <= 1'b0;
      r_sd_end_burst <= 1'b0;
      r_vid_ack      <= 1'b0;
      r_vid_valid    <= 1'b0;
      r_vid_done     <= 1'b0;
      r_rom_ack      <= 1'b0;
      r_rom_valid    <= 1'b0;
      r_rom_done     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_rom  <= w_grant_rom;
            r_sd_rd_addr <= w_grant_rom ? rom_addr : vid_addr;
            r_sd_rd      <= 1'b1;
            r_vid_ack    <= ~w_grant_rom;
            r_rom_ack    <= w_grant_rom;
            if (w_grant_rom || !rom_req) begin
              r_streak <= 4'd0;
            end else begin
              r_streak <= streak_sat_inc(r_streak);
            end
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_beat_cnt <= '0;
          r_wd_cnt   <= '0;
          r_state    <= S_DATA;
        end

        S_DATA: begin
          if (sd_data_available) begin
            if (r_owner_rom) begin
              r_rom_data  <= sd_out;
              r_rom_valid <= 1'b1;
            end else begin
              r_vid_data  <= sd_out;
              r_vid_valid <= 1'b1;
            end
            r_beat_cnt <= w_beat_inc;
            r_wd_cnt   <= '0;
            if (w_beat_inc == w_burst_len) begin
              r_sd_end_burst <= 1'b1;
              r_vid_done     <= ~r_owner_rom;
              r_rom_done     <= r_owner_rom;
              r_state        <= S_END;
            end
          end else begin
            r_wd_cnt <= w_wd_inc;
            // Silent controller: abort so the port is not held forever.
            if (w_wd_inc == WD_LIMIT) begin
              r_timeout_err  <= 1'b1;
              r_sd_end_burst <= 1'b1;
              r_vid_done     <= ~r_owner_rom;
              r_rom_done     <= r_owner_rom;
              r_state        <= S_END;
            end
          end
        end

        S_END: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sd_rd        = r_sd_rd;
  assign sd_rd_addr   = r_sd_rd_addr;
  assign sd_end_burst = r_sd_end_burst;
  assign timeout_err  = r_timeout_err;
  assign vid_ack      = r_vid_ack;
  assign vid_valid    = r_vid_valid;
  assign vid_data     = r_vid_data;
  assign vid_done     = r_vid_done;
  assign rom_ack      = r_rom_ack;
  assign rom_valid    = r_rom_valid;
  assign rom_data     = r_rom_data;
  assign rom_done     = r_rom_done;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Bench for sdram_read_arbiter: cycle vectors for single/simultaneous bursts, then
// hand sequences for starvation limit, gapped beats, watchdog abort and mid-burst reset.
module tb_sdram_read_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vid_req, rom_req;
  logic [24:0] vid_addr, rom_addr;
  logic        vid_ack, vid_valid, vid_done;
  logic        rom_ack, rom_valid, rom_done;
  logic [15:0] vid_data, rom_data;
  logic        sd_rd, sd_data_available, sd_end_burst, timeout_err;
  logic [24:0] sd_rd_addr;
  logic [15:0] sd_out;

  always #5 clk = ~clk;

  sdram_read_arbiter #(
    .VIDEO_BURST_LEN (8),
    .ROM_BURST_LEN   (1),
    .MAX_VIDEO_STREAK(4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_sys_99_287   (clk),
    .reset_n          (reset_n),
    .vid_req          (vid_req),
    .vid_addr         (vid_addr),
    .vid_ack          (vid_ack),
    .vid_valid        (vid_valid),
    .vid_data         (vid_data),
    .vid_done         (vid_done),
    .rom_req          (rom_req),
    .rom_addr         (rom_addr),
    .rom_ack          (rom_ack),
    .rom_valid        (rom_valid),
    .rom_data         (rom_data),
    .rom_done         (rom_done),
    .sd_rd            (sd_rd),
    .sd_rd_addr       (sd_rd_addr),
    .sd_data_available(sd_data_available),
    .sd_out           (sd_out),
    .sd_end_burst     (sd_end_burst),
    .timeout_err      (timeout_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        vreq;
    logic [24:0] vaddr;
    logic        rreq;
    logic [24:0] raddr;
    logic        da;
    logic [15:0] dout;
    logic        e_rd;
    logic [24:0] e_addr;
    logic        e_vack;
    logic        e_rack;
    logic        e_vval;
    logic        e_rval;
    logic [15:0] e_data;
    logic        e_end;
    logic        e_vdone;
    logic        e_rdone;
  } vec_t;

  vec_t vecs[$];

  int          vcnt, rcnt;
  logic [15:0] vbase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick and account for any valid beats, checking data order as they appear.
  task automatic tickm();
    tick();
    if (vid_valid === 1'b1) begin
      check("vid_data_order", 32'(vid_data), 32'(16'(vbase + 16'(vcnt))));
      vcnt++;
    end
    if (rom_valid === 1'b1) begin
      check("rom_data_order", 32'(rom_data), 32'(16'(16'h5A00 + 16'(rcnt))));
      rcnt++;
    end
  endtask

  function automatic vec_t mk(
    input logic vreq, input logic [24:0] vaddr, input logic rreq, input logic [24:0] raddr,
    input logic da, input logic [15:0] dout,
    input logic e_rd, input logic [24:0] e_addr, input logic e_vack, input logic e_rack,
    input logic e_vval, input logic e_rval, input logic [15:0] e_data,
    input logic e_end, input logic e_vdone, input logic e_rdone);
    vec_t v;
    v.vreq = vreq; v.vaddr = vaddr; v.rreq = rreq; v.raddr = raddr;
    v.da = da; v.dout = dout;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_vack = e_vack; v.e_rack = e_rack;
    v.e_vval = e_vval; v.e_rval = e_rval; v.e_data = e_data;
    v.e_end = e_end; v.e_vdone = e_vdone; v.e_rdone = e_rdone;
    return v;
  endfunction

  // Wait for a grant, feed the owner's burst, and confirm the burst closes on its last beat.
  task automatic serve(input bit drop, output logic own);
    int t;
    int len;
    t = 0;
    vcnt = 0;
    rcnt = 0;
    while (sd_rd !== 1'b1 && t < 50) begin
      tickm();
      t++;
    end
    check("serve_sd_rd_seen", 32'(sd_rd), 32'd1);
    if (sd_rd !== 1'b1) begin
      own = 1'b0;
      return;
    end
    own = rom_ack;
    check("serve_ack_onehot", 32'(vid_ack ^ rom_ack), 32'd1);
    if (drop) begin
      vid_req = 1'b0;
      rom_req = 1'b0;
    end
    tickm();
    len = own ? 1 : 8;
    for (int k = 0; k < len; k++) begin
      sd_data_available = 1'b1;
      sd_out = own ? 16'(16'h5A00 + 16'(k)) : 16'(vbase + 16'(k));
      tickm();
    end
    sd_data_available = 1'b0;
    check("serve_end_burst", 32'(sd_end_burst), 32'd1);
    check("serve_done", 32'(own ? rom_done : vid_done), 32'd1);
    check("serve_beat_count", 32'(own ? rcnt : vcnt), 32'(len));
    tickm();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic own;
    int   n;
    int   gap;

    reset_n = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    rom_req = 1'b0; rom_addr = '0;
    sd_data_available = 1'b0; sd_out = '0;

    // Single video burst, then simultaneous requests, then stray beats in IDLE.
    vecs.push_back(mk(1, 25'h1000, 0, 0, 0, 0,        1, 25'h1000, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 25'h1000, 0, 0, 0, 0,        0, 25'h1000, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 25'h1000, 0, 0, 1, 16'(16'hA000 + 16'(k)),
                        0, 25'h1000, 0, 0, 1, 0, 16'(16'hA000 + 16'(k)),
                        logic'(k == 7), logic'(k == 7), 0));
    vecs.push_back(mk(0, 25'h1000, 0, 0, 0, 0,        0, 25'h1000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 25'h2000, 1, 25'h0300, 0, 0, 1, 25'h2000, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 25'h2000, 1, 25'h0300, 0, 0, 0, 25'h2000, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 25'h2000, 1, 25'h0300, 1, 16'(16'hB000 + 16'(k)),
                        0, 25'h2000, 0, 0, 1, 0, 16'(16'hB000 + 16'(k)),
                        logic'(k == 7), logic'(k == 7), 0));
    vecs.push_back(mk(0, 25'h2000, 1, 25'h0300, 0, 0, 0, 25'h2000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 25'h2000, 1, 25'h0300, 0, 0, 1, 25'h0300, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 25'h2000, 0, 25'h0300, 0, 0, 0, 25'h0300, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 25'h2000, 0, 25'h0300, 1, 16'h5A5A,
                                                      0, 25'h0300, 0, 0, 0, 1, 16'h5A5A, 1, 0, 1));
    vecs.push_back(mk(0, 25'h2000, 0, 25'h0300, 0, 0, 0, 25'h0300, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 25'h2000, 0, 25'h0300, 1, 16'hDEAD, 0, 25'h0300, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 25'h2000, 0, 25'h0300, 1, 16'hBEEF, 0, 25'h0300, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_rd_addr", 32'(sd_rd_addr), 32'd0);
    check("rst_vid_data", 32'(vid_data), 32'd0);
    check("rst_rom_data", 32'(rom_data), 32'd0);
    check("rst_pulses", 32'({vid_ack, rom_ack, vid_valid, rom_valid, vid_done, rom_done, sd_end_burst}), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      vid_req = vecs[i].vreq; vid_addr = vecs[i].vaddr;
      rom_req = vecs[i].rreq; rom_addr = vecs[i].raddr;
      sd_data_available = vecs[i].da; sd_out = vecs[i].dout;
      tick();
      check($sformatf("row%0d_sd_rd", i), 32'(sd_rd), 32'(vecs[i].e_rd));
      check($sformatf("row%0d_sd_rd_addr", i), 32'(sd_rd_addr), 32'(vecs[i].e_addr));
      check($sformatf("row%0d_vid_ack", i), 32'(vid_ack), 32'(vecs[i].e_vack));
      check($sformatf("row%0d_rom_ack", i), 32'(rom_ack), 32'(vecs[i].e_rack));
      check($sformatf("row%0d_vid_valid", i), 32'(vid_valid), 32'(vecs[i].e_vval));
      check($sformatf("row%0d_rom_valid", i), 32'(rom_valid), 32'(vecs[i].e_rval));
      check($sformatf("row%0d_sd_end_burst", i), 32'(sd_end_burst), 32'(vecs[i].e_end));
      check($sformatf("row%0d_vid_done", i), 32'(vid_done), 32'(vecs[i].e_vdone));
      check($sformatf("row%0d_rom_done", i), 32'(rom_done), 32'(vecs[i].e_rdone));
      if (vecs[i].e_vval) check($sformatf("row%0d_vid_data", i), 32'(vid_data), 32'(vecs[i].e_data));
      if (vecs[i].e_rval) check($sformatf("row%0d_rom_data", i), 32'(rom_data), 32'(vecs[i].e_data));
      check($sformatf("row%0d_timeout_err", i), 32'(timeout_err), 32'd0);
    end
    vid_req = 1'b0; rom_req = 1'b0; sd_data_available = 1'b0;

    // Starvation limit: both held high, expect V V V V R V.
    vbase = 16'h6000;
    vid_req = 1'b1; vid_addr = 25'h6000;
    rom_req = 1'b1; rom_addr = 25'h0700;
    for (int g = 0; g < 6; g++) begin
      serve(1'b0, own);
      check($sformatf("starve_grant%0d_owner_rom", g), 32'(own), (g == 4) ? 32'd1 : 32'd0);
    end
    vid_req = 1'b0; rom_req = 1'b0;

    // Gapped beats, then stray beats while idle.
    vbase = 16'hC000; vcnt = 0; rcnt = 0;
    vid_req = 1'b1; vid_addr = 25'h3000;
    tickm();
    check("gap_sd_rd", 32'(sd_rd), 32'd1);
    check("gap_sd_rd_addr", 32'(sd_rd_addr), 32'h3000);
    vid_req = 1'b0;
    tickm();
    for (int k = 0; k < 8; k++) begin
      gap = int'($urandom_range(0, 5));
      sd_data_available = 1'b0;
      repeat (gap) tickm();
      sd_data_available = 1'b1;
      sd_out = 16'(16'hC000 + 16'(k));
      tickm();
    end
    sd_data_available = 1'b0;
    check("gap_end_burst", 32'(sd_end_burst), 32'd1);
    check("gap_vid_done", 32'(vid_done), 32'd1);
    check("gap_valid_count", 32'(vcnt), 32'd8);
    check("gap_timeout_err", 32'(timeout_err), 32'd0);
    tickm();
    sd_data_available = 1'b1; sd_out = 16'hFFFF;
    repeat (3) tickm();
    sd_data_available = 1'b0;
    check("stray_vid_valid_count", 32'(vcnt), 32'd8);
    check("stray_rom_valid_count", 32'(rcnt), 32'd0);

    // Watchdog abort after 3 beats.
    vbase = 16'hD000; vcnt = 0; rcnt = 0;
    vid_req = 1'b1; vid_addr = 25'h4000;
    tickm();
    vid_req = 1'b0;
    tickm();
    for (int k = 0; k < 3; k++) begin
      sd_data_available = 1'b1;
      sd_out = 16'(16'hD000 + 16'(k));
      tickm();
    end
    sd_data_available = 1'b0;
    n = 0;
    while (sd_end_burst !== 1'b1 && n < 40) begin
      tickm();
      n++;
    end
    check("wd_cycles_after_last_valid", 32'(n), 32'd16);
    check("wd_vid_done", 32'(vid_done), 32'd1);
    check("wd_rom_done", 32'(rom_done), 32'd0);
    check("wd_timeout_err_set", 32'(timeout_err), 32'd1);
    check("wd_valid_count", 32'(vcnt), 32'd3);
    tickm();
    check("wd_timeout_err_sticky", 32'(timeout_err), 32'd1);
    vbase = 16'hE000;
    vid_req = 1'b1; vid_addr = 25'h4100;
    serve(1'b1, own);
    check("wd_next_owner_rom", 32'(own), 32'd0);
    check("wd_timeout_err_after_next", 32'(timeout_err), 32'd1);

    // Reset in the middle of a burst.
    vbase = 16'hF000; vcnt = 0; rcnt = 0;
    vid_req = 1'b1; vid_addr = 25'h5000;
    tickm();
    vid_req = 1'b0;
    tickm();
    for (int k = 0; k < 4; k++) begin
      sd_data_available = 1'b1;
      sd_out = 16'(16'hF000 + 16'(k));
      tickm();
    end
    sd_data_available = 1'b0;
    check("mid_valid_before_reset", 32'(vcnt), 32'd4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sd_rd_addr", 32'(sd_rd_addr), 32'd0);
    check("mid_rst_vid_data", 32'(vid_data), 32'd0);
    check("mid_rst_pulses", 32'({sd_rd, vid_ack, rom_ack, vid_valid, rom_valid, vid_done, rom_done, sd_end_burst}), 32'd0);
    check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_rst_no_end", 32'({sd_end_burst, vid_done}), 32'd0);
    end
    reset_n = 1'b1;
    tick();
    check("post_rst_idle_sd_rd", 32'(sd_rd), 32'd0);
    vid_req = 1'b1; vid_addr = 25'h5000;
    tick();
    check("post_rst_sd_rd", 32'(sd_rd), 32'd1);
    check("post_rst_vid_ack", 32'(vid_ack), 32'd1);
    check("post_rst_sd_rd_addr", 32'(sd_rd_addr), 32'h5000);
    vid_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
